// File: rtl/sram_bridge_if.sv
// Request/response and SRAM pin bundle for sram_bridge.
// The bridge uses the slave view; the requester plus SRAM side uses the master view.
interface sram_bridge_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  logic              i_reqValid;
  logic              o_reqReady;
  logic              i_reqWr;
  logic [ADDR_W-1:0] i_reqAddr;
  logic [DATA_W-1:0] i_reqData;
  logic [BE_W-1:0]   i_reqBe;
  logic              o_rspValid;
  logic [DATA_W-1:0] o_rspData;

  logic [ADDR_W-1:0] o_sramAddr;
  logic [DATA_W-1:0] o_sramDqOut;
  logic              o_sramDqOe;
  logic [DATA_W-1:0] i_sramDq;
  logic              o_sramCeN;
  logic              o_sramOeN;
  logic              o_sramWeN;
  logic [BE_W-1:0]   o_sramBeN;

  modport slave (
    input  i_reqValid, i_reqWr, i_reqAddr, i_reqData, i_reqBe, i_sramDq,
    output o_reqReady, o_rspValid, o_rspData,
    output o_sramAddr, o_sramDqOut, o_sramDqOe, o_sramCeN, o_sramOeN, o_sramWeN, o_sramBeN
  );

  modport master (
    output i_reqValid, i_reqWr, i_reqAddr, i_reqData, i_reqBe, i_sramDq,
    input  o_reqReady, o_rspValid, o_rspData,
    input  o_sramAddr, o_sramDqOut, o_sramDqOe, o_sramCeN, o_sramOeN, o_sramWeN, o_sramBeN
  );
endinterface

// File: rtl/sram_bridge.sv
// Valid/ready request port to asynchronous SRAM sequencer with wait states,
// byte enables and read-to-write turnaround; every pin comes straight from a flop.
module sram_bridge #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int RD_WAIT  = 1,
  parameter int WR_WAIT  = 1,
  parameter int TURN_CYC = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sram_bridge_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] RD_CNT   = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT   = 4'(WR_WAIT);
  localparam logic [3:0] TURN_CNT = (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE, TURN, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_read_q, last_read_d;
  logic [ADDR_W-1:0] addr_l_q, addr_l_d;
  logic [DATA_W-1:0] data_l_q, data_l_d;
  logic [BE_W-1:0]   be_l_q, be_l_d;

  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic [BE_W-1:0]   be_n_q, be_n_d;

  // Sequencing: next state, counters, handshake and captured request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_read_d = last_read_q;
    addr_l_d    = addr_l_q;
    data_l_d    = data_l_q;
    be_l_d      = be_l_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.i_reqValid && ready_q) begin
          ready_d  = 1'b0;
          addr_l_d = bus.i_reqAddr;
          data_l_d = bus.i_reqData;
          be_l_d   = bus.i_reqBe;
          if (!bus.i_reqWr) begin
            state_d = RD_ACC;
            cnt_d   = RD_CNT;
          end else if (last_read_q && (TURN_CYC > 0)) begin
            state_d = TURN;
            cnt_d   = TURN_CNT;
          end else begin
            state_d = WR_SETUP;
          end
        end
      end
      TURN: begin
        if (cnt_q == 4'd0) state_d = WR_SETUP;
        else cnt_d = cnt_q - 4'd1;
      end
      RD_ACC: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = bus.i_sramDq;
          rsp_valid_d = 1'b1;
          last_read_d = 1'b1;
          ready_d     = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WR_CNT;
      end
      WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = WR_HOLD;
        else cnt_d = cnt_q - 4'd1;
      end
      WR_HOLD: begin
        state_d     = IDLE;
        last_read_d = 1'b0;
        ready_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin levels are decoded from the state being entered so they are valid
  // for the whole cycle the state lasts.
  always_comb begin
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    be_n_d      = '1;

    case (state_d)
      RD_ACC: begin
        sram_addr_d = addr_l_d;
        ce_n_d      = 1'b0;
        oe_n_d      = 1'b0;
        be_n_d      = '0;
      end
      WR_SETUP, WR_PULSE, WR_HOLD: begin
        sram_addr_d = addr_l_d;
        dq_out_d    = data_l_d;
        dq_oe_d     = 1'b1;
        ce_n_d      = 1'b0;
        be_n_d      = ~be_l_d;
        we_n_d      = (state_d != WR_PULSE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_read_q <= 1'b0;
      addr_l_q    <= '0;
      data_l_q    <= '0;
      be_l_q      <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_read_q <= last_read_d;
      addr_l_q    <= addr_l_d;
      data_l_q    <= data_l_d;
      be_l_q      <= be_l_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
    end
  end

  assign bus.o_reqReady  = ready_q;
  assign bus.o_rspValid  = rsp_valid_q;
  assign bus.o_rspData   = rsp_data_q;
  assign bus.o_sramAddr  = sram_addr_q;
  assign bus.o_sramDqOut = dq_out_q;
  assign bus.o_sramDqOe  = dq_oe_q;
  assign bus.o_sramCeN   = ce_n_q;
  assign bus.o_sramOeN   = oe_n_q;
  assign bus.o_sramWeN   = we_n_q;
  assign bus.o_sramBeN   = be_n_q;
endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: vector table, read scoreboard,
// SRAM behavioural model and pin-timing monitor.
module tb_sram_bridge;
  localparam int ADDR_W = 18, DATA_W = 16, RD_WAIT = 1, WR_WAIT = 1, TURN_CYC = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT),
    .WR_WAIT(WR_WAIT), .TURN_CYC(TURN_CYC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } sb_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  sb_t sb[$];

  logic [15:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

  assign bus.i_sramDq = (!bus.o_sramCeN && !bus.o_sramOeN) ? mem[bus.o_sramAddr[7:0]] : 16'h0000;

  always @(negedge clk)
    if (!rst && !bus.o_sramCeN && !bus.o_sramWeN)
      for (int b = 0; b < 2; b++)
        if (!bus.o_sramBeN[b]) mem[bus.o_sramAddr[7:0]][b*8 +: 8] <= bus.o_sramDqOut[b*8 +: 8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pin monitor: run lengths, transition spacing, invariants, response popping.
  int we_cnt = 0, oe_cnt = 0, rdy_cnt = 0;
  int last_we_run = 0, last_oe_run = 0, last_rdy_low = 0;
  logic [1:0] be_seen = 2'b00;
  logic prev_oen = 1'b1, prev_dqoe = 1'b0, prev_low = 1'b0;
  logic [35:0] prev_pins = '0;
  int oe_rise_cyc = 0, dq_fall_cyc = 0, gap_rw = -1, gap_wr = -1;

  always @(negedge clk) begin
    if (rst) begin
      we_cnt = 0; oe_cnt = 0; rdy_cnt = 0;
      prev_oen = 1'b1; prev_dqoe = 1'b0; prev_low = 1'b0;
    end else begin
      chk("oe_dqoe_overlap", {63'd0, (!bus.o_sramOeN && bus.o_sramDqOe)}, 64'd0);
      if (prev_low && (!bus.o_sramWeN || !bus.o_sramOeN))
        chk("pins_stable", {28'd0, bus.o_sramAddr, bus.o_sramDqOut, bus.o_sramBeN}, {28'd0, prev_pins});
      prev_low  = !bus.o_sramWeN || !bus.o_sramOeN;
      prev_pins = {bus.o_sramAddr, bus.o_sramDqOut, bus.o_sramBeN};

      if (!bus.o_sramWeN) begin we_cnt++; be_seen = bus.o_sramBeN; end
      else if (we_cnt != 0) begin last_we_run = we_cnt; we_cnt = 0; end
      if (!bus.o_sramOeN) oe_cnt++;
      else if (oe_cnt != 0) begin last_oe_run = oe_cnt; oe_cnt = 0; end
      if (!bus.o_reqReady) rdy_cnt++;
      else if (rdy_cnt != 0) begin last_rdy_low = rdy_cnt; rdy_cnt = 0; end

      if (bus.o_sramOeN && !prev_oen) oe_rise_cyc = cyc;
      if (!bus.o_sramOeN && prev_oen) gap_wr = cyc - dq_fall_cyc;
      if (bus.o_sramDqOe && !prev_dqoe) gap_rw = cyc - oe_rise_cyc;
      if (!bus.o_sramDqOe && prev_dqoe) dq_fall_cyc = cyc;
      prev_oen  = bus.o_sramOeN;
      prev_dqoe = bus.o_sramDqOe;

      if (bus.o_rspValid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp: got rspValid=1 data=0x%0h expected no response", bus.o_rspData);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("rsp_data", {48'd0, bus.o_rspData}, {48'd0, e.data});
          chk("rsp_latency", 64'(cyc - e.cyc), 64'(RD_WAIT + 1));
          $display("rsp  data=0x%04h exp=0x%04h latency=%0d", bus.o_rspData, e.data, cyc - e.cyc);
        end
      end
    end
  end

  // Present a request and return just after the edge that accepts it.
  task automatic do_req(input vec_t v, input bit hold);
    int t;
    bus.i_reqValid = 1'b1;
    bus.i_reqWr    = v.wr;
    bus.i_reqAddr  = v.addr;
    bus.i_reqData  = v.data;
    bus.i_reqBe    = v.be;
    t = 0;
    while (!bus.o_reqReady && t < 50) begin @(negedge clk); #1; t++; end
    if (t >= 50) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    @(negedge clk); #1;
    if (!v.wr) sb.push_back('{data: v.exp, cyc: cyc});
    if (!hold) bus.i_reqValid = 1'b0;
    $display("req  %s addr=0x%05h data=0x%04h be=%b", v.wr ? "WR" : "RD", v.addr, v.data, v.be);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!bus.o_reqReady && t < 100) begin @(negedge clk); #1; t++; end
    if (t >= 100) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  vec_t vecs[10];
  bit prev_read;

  initial begin
    vecs[0] = '{wr: 1'b1, addr: 18'h00012, data: 16'hBEEF, be: 2'b11, exp: 16'h0000};
    vecs[1] = '{wr: 1'b0, addr: 18'h00012, data: 16'h0000, be: 2'b00, exp: 16'hBEEF};
    vecs[2] = '{wr: 1'b1, addr: 18'h00012, data: 16'h1234, be: 2'b01, exp: 16'h0000};
    vecs[3] = '{wr: 1'b0, addr: 18'h00012, data: 16'h0000, be: 2'b00, exp: 16'hBE34};
    vecs[4] = '{wr: 1'b1, addr: 18'h00020, data: 16'hA5A5, be: 2'b11, exp: 16'h0000};
    vecs[5] = '{wr: 1'b1, addr: 18'h00021, data: 16'h5A5A, be: 2'b10, exp: 16'h0000};
    vecs[6] = '{wr: 1'b0, addr: 18'h00021, data: 16'h0000, be: 2'b00, exp: 16'h5A00};
    vecs[7] = '{wr: 1'b1, addr: 18'h00020, data: 16'hFFFF, be: 2'b00, exp: 16'h0000};
    vecs[8] = '{wr: 1'b0, addr: 18'h00020, data: 16'h0000, be: 2'b00, exp: 16'hA5A5};
    vecs[9] = '{wr: 1'b0, addr: 18'h00000, data: 16'h0000, be: 2'b00, exp: 16'h0000};

    bus.i_reqValid = 1'b0; bus.i_reqWr = 1'b0; bus.i_reqAddr = '0;
    bus.i_reqData = '0; bus.i_reqBe = '0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {63'd0, bus.o_reqReady}, 64'd0);
    chk("rst_rsp", {47'd0, bus.o_rspValid, bus.o_rspData}, 64'd0);
    chk("rst_strobes", {58'd0, bus.o_sramCeN, bus.o_sramOeN, bus.o_sramWeN, bus.o_sramBeN, bus.o_sramDqOe}, 64'b111110);
    chk("rst_addr_dq", {30'd0, bus.o_sramAddr, bus.o_sramDqOut}, 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rel_ready", {63'd0, bus.o_reqReady}, 64'd1);
    chk("rel_strobes", {58'd0, bus.o_sramCeN, bus.o_sramOeN, bus.o_sramWeN, bus.o_sramBeN, bus.o_sramDqOe}, 64'b111110);
    @(negedge clk); #1;
    chk("idle_ben", {62'd0, bus.o_sramBeN}, 64'b11);

    // Table of isolated transactions
    prev_read = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i], 1'b0);
      wait_idle();
      if (vecs[i].wr) begin
        chk("wr_wen_low", 64'(last_we_run), 64'(WR_WAIT + 1));
        chk("wr_ready_low", 64'(last_rdy_low), 64'(WR_WAIT + 3 + (prev_read ? TURN_CYC : 0)));
        chk("wr_ben", {62'd0, be_seen}, {62'd0, ~vecs[i].be});
      end else begin
        chk("rd_oen_low", 64'(last_oe_run), 64'(RD_WAIT + 1));
        chk("rd_ready_low", 64'(last_rdy_low), 64'(RD_WAIT + 1));
        chk("rd_rsp_seen", 64'(sb.size()), 64'd0);
      end
      prev_read = !vecs[i].wr;
    end

    // Back-to-back read, write, read with valid held high
    gap_rw = -1; gap_wr = -1;
    do_req('{wr: 1'b0, addr: 18'h00012, data: 16'h0000, be: 2'b00, exp: 16'hBE34}, 1'b1);
    do_req('{wr: 1'b1, addr: 18'h00030, data: 16'h7777, be: 2'b11, exp: 16'h0000}, 1'b1);
    do_req('{wr: 1'b0, addr: 18'h00030, data: 16'h0000, be: 2'b00, exp: 16'h7777}, 1'b0);
    wait_idle();
    chk("b2b_turn_gap", 64'(gap_rw), 64'(1 + TURN_CYC));
    chk("b2b_no_turn_gap", 64'(gap_wr), 64'd1);
    chk("b2b_rsp_seen", 64'(sb.size()), 64'd0);

    // Reset asserted during the second WeN-low cycle of a write
    begin
      int n, t;
      bus.i_reqValid = 1'b1; bus.i_reqWr = 1'b1; bus.i_reqAddr = 18'h00050;
      bus.i_reqData = 16'hCAFE; bus.i_reqBe = 2'b11;
      t = 0;
      while (!bus.o_reqReady && t < 50) begin @(negedge clk); #1; t++; end
      @(posedge clk);
      @(negedge clk); #1;
      bus.i_reqValid = 1'b0;
      n = 0; t = 0;
      while (t < 20) begin
        if (!bus.o_sramWeN) n++;
        if (n == 2) break;
        @(negedge clk); #1; t++;
      end
      chk("abort_reached_pulse", 64'(n), 64'd2);
      rst = 1'b1;
      #1;
      chk("abort_strobes", {60'd0, bus.o_sramWeN, bus.o_sramCeN, bus.o_sramDqOe, bus.o_reqReady}, 64'b1100);
      chk("abort_rsp", {63'd0, bus.o_rspValid}, 64'd0);
      @(negedge clk); @(negedge clk); #1;
      rst = 1'b0;
      $display("rst  asserted mid write pulse, released");
      repeat (3) @(negedge clk);
      #1;
      chk("abort_no_rsp", {63'd0, bus.o_rspValid}, 64'd0);
    end

    prev_read = 1'b0;
    do_req('{wr: 1'b1, addr: 18'h00040, data: 16'h0F0F, be: 2'b11, exp: 16'h0000}, 1'b0);
    wait_idle();
    chk("post_rst_wr_ready_low", 64'(last_rdy_low), 64'(WR_WAIT + 3));
    do_req('{wr: 1'b0, addr: 18'h00040, data: 16'h0000, be: 2'b00, exp: 16'h0F0F}, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Parametrised, fully registered bridge between a valid/ready memory request port and an asynchronous SRAM chip.
- Replaces hand-built chip-pin glue with a sequenced controller: configurable read/write wait states, per-byte write enables, and read-to-write bus turnaround.
- Sits in the dev chassis between the DUT memory port and the SRAM_* pins, on the generated core clock.

Parameters:
- ADDR_W, 18: SRAM address width.
- DATA_W, 16: data width; must be a multiple of 8.
- RD_WAIT, 1: extra read access cycles beyond one; range 0..15.
- WR_WAIT, 1: extra write-enable-low cycles beyond one; range 0..15.
- TURN_CYC, 1: idle cycles inserted between a read and a following write; range 0..3.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_reqValid  in  1  request valid.
- o_reqReady  out  1  bridge can accept a request.
- i_reqWr  in  1  1 = write, 0 = read.
- i_reqAddr  in  ADDR_W  word address.
- i_reqData  in  DATA_W  write data.
- i_reqBe  in  DATA_W/8  write byte enables, active-high.
- o_rspValid  out  1  one-cycle pulse when read data is valid.
- o_rspData  out  DATA_W  read data.
- o_sramAddr  out  ADDR_W  SRAM address.
- o_sramDqOut  out  DATA_W  data driven to the SRAM.
- o_sramDqOe  out  1  1 = drive the DQ pins.
- i_sramDq  in  DATA_W  DQ pin input.
- o_sramCeN  out  1  chip enable, active-low.
- o_sramOeN  out  1  output enable, active-low.
- o_sramWeN  out  1  write enable, active-low.
- o_sramBeN  out  DATA_W/8  byte enables, active-low.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. Every output is driven from a flop.
- Reset values while i_rst is high:
  - o_sramCeN = o_sramOeN = o_sramWeN = 1; o_sramBeN all 1.
  - o_sramDqOe = 0; o_sramAddr = 0; o_sramDqOut = 0.
  - o_reqReady = 0; o_rspValid = 0; o_rspData = 0.
  - State IDLE; lastRead = 0.
- First edge after reset release: o_reqReady = 1.
- Asserting i_rst mid-operation aborts the operation immediately. The SRAM returns to idle pin levels, and no response is produced.
- Acceptance: a request is accepted on an edge where i_reqValid & o_reqReady. At that edge:
  - i_reqWr, i_reqAddr, i_reqData and i_reqBe are latched.
  - o_reqReady falls and stays low until the operation completes.
- States: IDLE, TURN, RD_ACC, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE:
  - CeN = OeN = WeN = 1; DqOe = 0; o_reqReady = 1.
  - Accepted read -> RD_ACC.
  - Accepted write with lastRead = 1 and TURN_CYC > 0 -> TURN.
  - Any other accepted write -> WR_SETUP.
- TURN:
  - All strobes inactive; DqOe = 0.
  - Lasts TURN_CYC cycles -> WR_SETUP.
- RD_ACC:
  - Addr = latched address; CeN = 0; OeN = 0; BeN all 0; DqOe = 0.
  - Lasts RD_WAIT+1 cycles.
  - On its final edge: o_rspData <= i_sramDq, o_rspValid <= 1, lastRead <= 1, go to IDLE.
- o_rspValid is high exactly one cycle, coincident with the first IDLE cycle.
- Read latency: o_rspValid is high in the cycle following the (RD_WAIT+1)th edge after the accepting edge.
- o_rspData holds its value until the next read captures.
- WR_SETUP:
  - Lasts 1 cycle.
  - Addr = latched address; CeN = 0; OeN = 1; WeN = 1.
  - DqOe = 1; DqOut = latched data; BeN = ~latched Be.
- WR_PULSE: same as WR_SETUP but WeN = 0; lasts WR_WAIT+1 cycles.
- WR_HOLD:
  - Lasts 1 cycle.
  - WeN = 1; CeN = 0; DqOe = 1; address, data and BeN held.
  - Then IDLE with lastRead <= 0.
- A write occupies WR_WAIT+3 cycles, plus TURN_CYC when it follows a read.
- Write with i_reqBe = 0: the full cycle executes with BeN all 1, so no SRAM change.
- Address, data and BeN never change while WeN = 0 or OeN = 0.
- OeN = 0 and DqOe = 1 never hold in the same cycle.
- Back-to-back requests: with i_reqValid held high, the next request is accepted in the first IDLE cycle. There are no dead cycles other than TURN.
- Requests presented while o_reqReady = 0 are not accepted. The requester must hold them stable until accepted.

Test Plan:
(Parameters: RD_WAIT=1, WR_WAIT=1, TURN_CYC=1, DATA_W=16.)
- Reset release, no request -> first edge o_reqReady=1; CeN/OeN/WeN=1; DqOe=0; BeN=2'b11 throughout.
- Write addr 0x00012, data 0xBEEF, Be=2'b11 -> WR_SETUP 1 cycle, WeN low exactly 2 cycles, WR_HOLD 1 cycle; o_reqReady low 4 cycles; SRAM model holds 0xBEEF.
- Read 0x00012 from that model -> OeN low exactly 2 cycles; o_rspValid high 1 cycle, 2 edges after acceptance; o_rspData=0xBEEF.
- Write Be=2'b01, data 0x1234, to a location holding 0xBEEF -> BeN=2'b10 during the write; a subsequent read returns 0xBE34.
- Read then immediate write with i_reqValid held high -> exactly 1 TURN cycle with DqOe=0 and OeN=1 between OeN rising and DqOe rising; write-then-read back-to-back -> no TURN cycle.
- Assert i_rst during the second WeN-low cycle -> same cycle: WeN=1, CeN=1, DqOe=0, o_reqReady=0; no o_rspValid; after release the bridge accepts a new request normally.
